// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port synchronous RAM.
// Optional IF starvation guard is compiled in with macro ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [3:0]            lsu_be,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [31:0]           lsu_wdata,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_IF  = 2'd1;
    localparam logic [1:0] RD_LSU = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       force_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    assign force_if = (starve_cnt == LIMIT);

    // Count consecutive cycles IF is refused, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end
`else
    // Guard disabled: LSU always wins; the limit only shapes the interface
    assign force_if = (STARVE_LIMIT < 0);
`endif

    // Grant decision: LSU first unless IF has been starved too long
    always_comb begin
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && (!lsu_req || force_if)) begin
                if_gnt = 1'b1;
            end else if (lsu_req) begin
                lsu_gnt = 1'b1;
            end
        end
    end

    // Route the winner onto the memory port in the grant cycle
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = if_addr;
        mem_wdata = 32'h0;
        if (lsu_gnt) begin
            mem_req   = 1'b1;
            mem_we    = lsu_we;
            mem_be    = lsu_be;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
        end else if (if_gnt) begin
            mem_req   = 1'b1;
            mem_be    = 4'hF;
        end
    end

    // Remember who owns the read that returns next cycle
    always_comb begin
        unique case (1'b1)
            if_gnt:             state_nxt = RD_IF;
            lsu_gnt && !lsu_we: state_nxt = RD_LSU;
            default:            state_nxt = IDLE;
        endcase
    end

    // Response state register; reset drops any read in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign if_rvalid  = (state == RD_IF);
    assign lsu_rvalid = (state == RD_LSU);
    assign rsp_rdata  = (state != IDLE) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, starvation
// sequence and randomized traffic against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW  = 12;
    localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic          if_rvalid;
    logic          lsu_req = 1'b0;
    logic          lsu_we = 1'b0;
    logic [3:0]    lsu_be = 4'h0;
    logic [AW-1:0] lsu_addr = '0;
    logic [31:0]   lsu_wdata = 32'h0;
    logic          lsu_gnt;
    logic          lsu_rvalid;
    logic [31:0]   rsp_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    logic [31:0] ram [4096];
    logic [31:0] ref_mem [4096];

    int n_cmp = 0;
    int n_bad = 0;

    // model state: who owns the next response, and IF loss streak
    int          pend = 0;
    logic [31:0] pdata = 32'h0;
    int          loss = 0;
    bit          last_gi = 1'b0;
    bit          last_gl = 1'b0;

    mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .rsp_rdata(rsp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM environment
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [11:0] iaddr;
        logic        lreq;
        logic        lwe;
        logic [3:0]  lbe;
        logic [11:0] laddr;
        logic [31:0] lwd;
        logic        e_ig;
        logic        e_lg;
        logic        e_we;
        logic [3:0]  e_be;
        logic [11:0] e_addr;
        logic        e_irv;
        logic        e_lrv;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        logic rst, logic ireq, logic [11:0] iaddr,
        logic lreq, logic lwe, logic [3:0] lbe, logic [11:0] laddr,
        logic [31:0] lwd, logic e_ig, logic e_lg, logic e_we,
        logic [3:0] e_be, logic [11:0] e_addr,
        logic e_irv, logic e_lrv, logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.iaddr = iaddr;
        v.lreq = lreq; v.lwe = lwe; v.lbe = lbe; v.laddr = laddr;
        v.lwd = lwd; v.e_ig = e_ig; v.e_lg = e_lg; v.e_we = e_we;
        v.e_be = e_be; v.e_addr = e_addr;
        v.e_irv = e_irv; v.e_lrv = e_lrv; v.e_rd = e_rd;
        return v;
    endfunction

    // Reference model: checks this cycle's outputs, then commits its effects
    task automatic model_cycle(input string tag);
        bit gi;
        bit gl;
        if (!rst_n) begin
            pend = 0;
            loss = 0;
        end
        gi = rst_n && if_req && (!lsu_req || (GUARD && loss >= LIM));
        gl = rst_n && lsu_req && !gi;
        chk({tag, ".if_gnt"}, 64'(if_gnt), 64'(gi));
        chk({tag, ".lsu_gnt"}, 64'(lsu_gnt), 64'(gl));
        chk({tag, ".mem_req"}, 64'(mem_req), 64'(gi || gl));
        chk({tag, ".mem_we"}, 64'(mem_we), 64'(gl && lsu_we));
        chk({tag, ".mem_be"}, 64'(mem_be),
            64'(gl ? lsu_be : (gi ? 4'hF : 4'h0)));
        if (gi) chk({tag, ".addr_if"}, 64'(mem_addr), 64'(if_addr));
        if (gl) chk({tag, ".addr_lsu"}, 64'(mem_addr), 64'(lsu_addr));
        if (gl && lsu_we) chk({tag, ".wdata"}, 64'(mem_wdata), 64'(lsu_wdata));
        chk({tag, ".if_rvalid"}, 64'(if_rvalid), 64'(pend == 1));
        chk({tag, ".lsu_rvalid"}, 64'(lsu_rvalid), 64'(pend == 2));
        chk({tag, ".rdata"}, 64'(rsp_rdata), 64'(pend != 0 ? pdata : 32'h0));
        pend = 0;
        if (gi) begin
            pend = 1;
            pdata = ref_mem[if_addr];
        end else if (gl && !lsu_we) begin
            pend = 2;
            pdata = ref_mem[lsu_addr];
        end else if (gl) begin
            for (int b = 0; b < 4; b++)
                if (lsu_be[b]) ref_mem[lsu_addr][8*b +: 8] = lsu_wdata[8*b +: 8];
        end
        if (rst_n && if_req && !gi) loss = (loss + 1 > LIM) ? LIM : loss + 1;
        else loss = 0;
        last_gi = gi;
        last_gl = gl;
    endtask

    vec_t vt[13];
    int   first_if;
    int   n_if;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        ram[12'h010] = 32'hDEADBEEF;
        ram[12'h200] = 32'h12345678;
        ram[12'h020] = 32'hCAFE0020;
        ram[12'h300] = 32'h11223344;

        vt[0]  = mk(0, 1, 12'h010, 1, 0, 4'hF, 12'h200, 0,
                    0, 0, 0, 4'h0, 12'h000, 0, 0, 32'h0);
        vt[1]  = mk(1, 1, 12'h010, 0, 0, 4'h0, 12'h000, 0,
                    1, 0, 0, 4'hF, 12'h010, 0, 0, 32'h0);
        vt[2]  = mk(1, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 1, 0, 32'hDEADBEEF);
        vt[3]  = mk(1, 1, 12'h020, 1, 0, 4'hF, 12'h200, 0,
                    0, 1, 0, 4'hF, 12'h200, 0, 0, 32'h0);
        vt[4]  = mk(1, 1, 12'h020, 0, 0, 4'h0, 12'h000, 0,
                    1, 0, 0, 4'hF, 12'h020, 0, 1, 32'h12345678);
        vt[5]  = mk(1, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 1, 0, 32'hCAFE0020);
        vt[6]  = mk(1, 0, 12'h000, 1, 1, 4'b0011, 12'h300, 32'h0000ABCD,
                    0, 1, 1, 4'b0011, 12'h300, 0, 0, 32'h0);
        vt[7]  = mk(1, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 0, 0, 32'h0);
        vt[8]  = mk(1, 0, 12'h000, 1, 0, 4'hF, 12'h300, 0,
                    0, 1, 0, 4'hF, 12'h300, 0, 0, 32'h0);
        vt[9]  = mk(1, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 0, 1, 32'h1122ABCD);
        vt[10] = mk(1, 1, 12'h010, 0, 0, 4'h0, 12'h000, 0,
                    1, 0, 0, 4'hF, 12'h010, 0, 0, 32'h0);
        vt[11] = mk(0, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 0, 0, 32'h0);
        vt[12] = mk(1, 0, 12'h000, 0, 0, 4'h0, 12'h000, 0,
                    0, 0, 0, 4'h0, 12'h000, 0, 0, 32'h0);

        @(posedge clk);
        #1;
        // directed vectors, one row per cycle
        for (int r = 0; r < 13; r++) begin
            rst_n = vt[r].rst;
            if_req = vt[r].ireq;
            if_addr = vt[r].iaddr;
            lsu_req = vt[r].lreq;
            lsu_we = vt[r].lwe;
            lsu_be = vt[r].lbe;
            lsu_addr = vt[r].laddr;
            lsu_wdata = vt[r].lwd;
            #4;
            chk($sformatf("vec%0d.if_gnt", r), 64'(if_gnt), 64'(vt[r].e_ig));
            chk($sformatf("vec%0d.lsu_gnt", r), 64'(lsu_gnt), 64'(vt[r].e_lg));
            chk($sformatf("vec%0d.mem_req", r), 64'(mem_req),
                64'(vt[r].e_ig | vt[r].e_lg));
            chk($sformatf("vec%0d.mem_we", r), 64'(mem_we), 64'(vt[r].e_we));
            chk($sformatf("vec%0d.mem_be", r), 64'(mem_be), 64'(vt[r].e_be));
            if (vt[r].e_ig | vt[r].e_lg)
                chk($sformatf("vec%0d.mem_addr", r), 64'(mem_addr),
                    64'(vt[r].e_addr));
            if (vt[r].e_we)
                chk($sformatf("vec%0d.wdata", r), 64'(mem_wdata), 64'(vt[r].lwd));
            chk($sformatf("vec%0d.if_rvalid", r), 64'(if_rvalid), 64'(vt[r].e_irv));
            chk($sformatf("vec%0d.lsu_rvalid", r), 64'(lsu_rvalid),
                64'(vt[r].e_lrv));
            chk($sformatf("vec%0d.rdata", r), 64'(rsp_rdata), 64'(vt[r].e_rd));
            @(posedge clk);
            #1;
        end

        // starvation: both requesters hold their requests continuously
        for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
        rst_n = 1'b0;
        if_req = 1'b1;
        if_addr = 12'h006;
        lsu_req = 1'b1;
        lsu_we = 1'b0;
        lsu_be = 4'hF;
        lsu_addr = 12'h005;
        #4;
        model_cycle("starve_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        first_if = -1;
        n_if = 0;
        for (int k = 0; k < 12; k++) begin
            #4;
            if (if_gnt && first_if < 0) first_if = k;
            if (if_gnt) n_if++;
            model_cycle($sformatf("starve%0d", k));
            @(posedge clk);
            #1;
        end
        chk("starve.first_if", 64'(first_if), GUARD ? 64'(4) : 64'(-1));
        chk("starve.if_count", 64'(n_if), GUARD ? 64'(2) : 64'(0));

        // randomized traffic; requesters hold until granted
        if_req = 1'b0;
        lsu_req = 1'b0;
        last_gi = 1'b0;
        last_gl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            if (!if_req || last_gi) begin
                if_req = ($urandom_range(0, 3) != 0);
                if_addr = 12'($urandom_range(0, 15));
            end
            if (!lsu_req || last_gl) begin
                lsu_req = ($urandom_range(0, 2) != 0);
                lsu_we = $urandom_range(0, 1) == 1;
                lsu_be = 4'($urandom_range(0, 15));
                lsu_addr = 12'($urandom_range(0, 15));
                lsu_wdata = $urandom;
            end
            #4;
            model_cycle($sformatf("rnd%0d", c));
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address width (4096-word memory).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive IF losses before forced IF grant (used only when ARB_STARVE_GUARD_EN is defined).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  fetch read request.
REQ-006 SHALL have port if_addr  input  ADDR_WIDTH  fetch word address.
REQ-007 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid  output  1  fetch read data valid on rsp_rdata.
REQ-009 SHALL have port lsu_req  input  1  load/store request.
REQ-010 SHALL have port lsu_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port lsu_be  input  4  store byte enables (bit i = byte i).
REQ-012 SHALL have port lsu_addr  input  ADDR_WIDTH  load/store word address.
REQ-013 SHALL have port lsu_wdata  input  32  store data.
REQ-014 SHALL have port lsu_gnt  output  1  LSU request accepted this cycle.
REQ-015 SHALL have port lsu_rvalid  output  1  load data valid on rsp_rdata.
REQ-016 SHALL have port rsp_rdata  output  32  read data returned to the owner of the pending read.
REQ-017 SHALL have port mem_req  output  1  memory access this cycle.
REQ-018 SHALL have port mem_we  output  1  memory write strobe.
REQ-019 SHALL have port mem_be  output  4  memory byte enables.
REQ-020 SHALL have port mem_addr  output  ADDR_WIDTH  memory word address.
REQ-021 SHALL have port mem_wdata  output  32  memory write data.
REQ-022 SHALL have port mem_rdata  input  32  synchronous single-port RAM read data, valid one cycle after mem_req with mem_we=0.

Function
REQ-023 SHALL grant at most one requester per cycle; if_gnt and lsu_gnt never both 1.
REQ-024 SHALL grant combinationally in the request cycle; a requester holds req/addr/data stable until it sees gnt.
REQ-025 SHALL give LSU priority over IF when both request, except as in REQ-037.
REQ-026 SHALL drive mem_req=1 and route the granted requester's addr/we/be/wdata to mem_* in the grant cycle; IF grant drives mem_we=0, mem_be=4'hF.
REQ-027 SHALL drive mem_req=0, mem_we=0, mem_be=0 when no grant.
REQ-028 SHALL use a response FSM: IDLE (no read pending), RD_IF (IF read pending), RD_LSU (load pending).
REQ-029 SHALL transition next-state per cycle: IF grant -> RD_IF; LSU load grant -> RD_LSU; LSU store grant or no grant -> IDLE; independent of current state.
REQ-030 SHALL assert if_rvalid=1 in RD_IF and lsu_rvalid=1 in RD_LSU, one cycle after grant, with rsp_rdata=mem_rdata; rsp_rdata=0 in IDLE.
REQ-031 SHALL sustain back-to-back grants (one per cycle), so a response and a new grant may coincide.
REQ-032 SHALL issue no response for stores; lsu_gnt is the store's completion.
REQ-033 SHALL pass lsu_be unmodified; alignment and byte lane steering are the LSU's responsibility.

Reset
REQ-034 SHALL force state=IDLE, if_rvalid=0, lsu_rvalid=0, rsp_rdata=0, starve counter=0 immediately on rst_n=0, independent of clk.
REQ-035 SHALL discard any read pending at reset assertion; its response is never delivered; no grant while rst_n=0.

Configuration
REQ-036 SHALL compile the starvation guard only when macro ARB_STARVE_GUARD_EN is defined.
REQ-037 With ARB_STARVE_GUARD_EN: counter increments when if_req=1 and IF not granted, clears on if_gnt or if_req=0, saturates at STARVE_LIMIT; at STARVE_LIMIT IF wins over LSU for one grant. Without it: strict LSU priority, no counter.

Verification
REQ-038 Reset: rst_n=0 with if_req=lsu_req=1 -> no gnt, both rvalid=0, mem_req=0.
REQ-039 IF read: if_req=1, if_addr=12'h010, mem_rdata=32'hDEADBEEF next cycle -> if_gnt cycle N, if_rvalid=1 with rsp_rdata=32'hDEADBEEF cycle N+1.
REQ-040 Collision: if_req=lsu_req=1, lsu_we=0, lsu_addr=12'h200 -> lsu_gnt N, lsu_rvalid N+1; if_gnt N+1, if_rvalid N+2.
REQ-041 Store: lsu_we=1, lsu_be=4'b0011, lsu_wdata=32'h0000ABCD -> mem_we=1, mem_be=4'b0011 same cycle; no rvalid next cycle.
REQ-042 Starvation (macro defined, STARVE_LIMIT=4): lsu_req and if_req held 1 -> lsu_gnt 4 cycles, if_gnt 5th cycle, then lsu_gnt resumes; macro undefined -> if_gnt never.
REQ-043 Reset mid-read: rst_n=0 one cycle after if_gnt -> if_rvalid stays 0.
